// File: rtl/find_stars_pkg.sv
// Shared definitions for the star finder pipeline: FSM encodings, box field
// widths and the default pixel colours.
package find_stars_pkg;

  localparam int BOX_X_W   = 8;
  localparam int BOX_Y_W   = 7;
  localparam int DEF_COL_W = 3;

  localparam logic [DEF_COL_W-1:0] DEF_BG_COLOUR  = 3'b000;
  localparam logic [DEF_COL_W-1:0] DEF_BOX_COLOUR = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FLUSH,
    ST_DRAW,
    ST_DONE
  } state_e;

  // Outline segments, plotted in this order for every box.
  typedef enum logic [1:0] {
    PH_TOP,
    PH_BOT,
    PH_LEFT,
    PH_RIGHT
  } draw_phase_e;

endpackage

// File: rtl/star_box_table.sv
// Bounding-box table: hit test against every valid box, lowest-index select,
// in-place extension or allocation, and a read port for the draw phase.
module star_box_table
  import find_stars_pkg::*;
#(
  parameter int X_W       = BOX_X_W,
  parameter int Y_W       = BOX_Y_W,
  parameter int MAX_STARS = 4,
  parameter int MERGE_GAP = 1,
  parameter int CNT_W     = $clog2(MAX_STARS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             pix_valid_i,
  input  logic             pix_star_i,
  input  logic [X_W-1:0]   pix_x_i,
  input  logic [Y_W-1:0]   pix_y_i,
  output logic             alloc_o,
  output logic             full_o,
  input  logic [CNT_W-1:0] rd_idx_i,
  output logic [X_W-1:0]   rd_xmin_o,
  output logic [X_W-1:0]   rd_xmax_o,
  output logic [Y_W-1:0]   rd_ymin_o,
  output logic [Y_W-1:0]   rd_ymax_o
);

  localparam int IDX_W = (MAX_STARS > 1) ? $clog2(MAX_STARS) : 1;
  localparam logic [X_W:0] GAP_X = (X_W + 1)'(MERGE_GAP);
  localparam logic [Y_W:0] GAP_Y = (Y_W + 1)'(MERGE_GAP);

  logic [MAX_STARS-1:0] valid_q;
  logic [X_W-1:0]       xmin_q [MAX_STARS];
  logic [X_W-1:0]       xmax_q [MAX_STARS];
  logic [Y_W-1:0]       ymin_q [MAX_STARS];
  logic [Y_W-1:0]       ymax_q [MAX_STARS];

  logic             hit_any, free_any, star_px;
  logic [IDX_W-1:0] hit_idx, free_idx;
  logic [X_W:0]     px_e;
  logic [Y_W:0]     py_e;

  assign px_e    = {1'b0, pix_x_i};
  assign py_e    = {1'b0, pix_y_i};
  assign star_px = pix_valid_i && pix_star_i;

  // NOTE: every variable driven here gets a default first, otherwise the
  // paths that skip an assignment infer latches.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    // Walking downwards leaves the lowest matching index selected.
    for (int i = MAX_STARS - 1; i >= 0; i--) begin
      if (valid_q[i] &&
          (px_e + GAP_X >= {1'b0, xmin_q[i]}) && (px_e <= {1'b0, xmax_q[i]} + GAP_X) &&
          (py_e + GAP_Y >= {1'b0, ymin_q[i]}) && (py_e <= {1'b0, ymax_q[i]} + GAP_Y)) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign alloc_o = star_px && !hit_any && free_any;
  assign full_o  = star_px && !hit_any && !free_any;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      valid_q <= '0;
    end else if (alloc_o) begin
      valid_q[free_idx] <= 1'b1;
    end
  end

  // NOTE: box coordinates are deliberately not reset; the valid bits gate
  // every use of them, so stale contents are never observed.
  // Updating at the classifying edge means the following pixel's hit test
  // already sees the extended box.
  always_ff @(posedge clk) begin
    if (star_px && hit_any) begin
      if (pix_x_i < xmin_q[hit_idx]) xmin_q[hit_idx] <= pix_x_i;
      if (pix_x_i > xmax_q[hit_idx]) xmax_q[hit_idx] <= pix_x_i;
      if (pix_y_i < ymin_q[hit_idx]) ymin_q[hit_idx] <= pix_y_i;
      if (pix_y_i > ymax_q[hit_idx]) ymax_q[hit_idx] <= pix_y_i;
    end else if (alloc_o) begin
      xmin_q[free_idx] <= pix_x_i;
      xmax_q[free_idx] <= pix_x_i;
      ymin_q[free_idx] <= pix_y_i;
      ymax_q[free_idx] <= pix_y_i;
    end
  end

  always_comb begin
    rd_xmin_o = '0;
    rd_xmax_o = '0;
    rd_ymin_o = '0;
    rd_ymax_o = '0;
    for (int i = 0; i < MAX_STARS; i++) begin
      if (rd_idx_i == CNT_W'(i)) begin
        rd_xmin_o = xmin_q[i];
        rd_xmax_o = xmax_q[i];
        rd_ymin_o = ymin_q[i];
        rd_ymax_o = ymax_q[i];
      end
    end
  end

endmodule

// File: rtl/multi_star_finder.sv
// Raster-scans the frame memory, clusters star pixels into boxes, then plots
// a padded outline around every box through the vga_adapter interface.
module multi_star_finder
  import find_stars_pkg::*;
#(
  parameter int               X_W        = BOX_X_W,
  parameter int               Y_W        = BOX_Y_W,
  parameter int               COL_W      = DEF_COL_W,
  parameter int               SCREEN_W   = 160,
  parameter int               SCREEN_H   = 120,
  parameter int               MAX_STARS  = 4,
  parameter int               MERGE_GAP  = 1,
  parameter int               BOX_PAD    = 1,
  parameter logic [COL_W-1:0] BG_COLOUR  = DEF_BG_COLOUR,
  parameter logic [COL_W-1:0] BOX_COLOUR = DEF_BOX_COLOUR
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  output logic                               rd_en,
  output logic [X_W-1:0]                     rd_x,
  output logic [Y_W-1:0]                     rd_y,
  input  logic [COL_W-1:0]                   rd_data,
  output logic [X_W-1:0]                     x,
  output logic [Y_W-1:0]                     y,
  output logic [COL_W-1:0]                   colour,
  output logic                               plot,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(MAX_STARS + 1)-1:0]   star_count,
  output logic                               overflow
);

  localparam int CNT_W = $clog2(MAX_STARS + 1);
  localparam int OFF_W = (X_W > Y_W) ? X_W : Y_W;
  localparam logic [X_W:0] PAD_X = (X_W + 1)'(BOX_PAD);
  localparam logic [Y_W:0] PAD_Y = (Y_W + 1)'(BOX_PAD);
  localparam logic [X_W:0] MAX_X = (X_W + 1)'(SCREEN_W - 1);
  localparam logic [Y_W:0] MAX_Y = (Y_W + 1)'(SCREEN_H - 1);

  state_e            state_q;
  draw_phase_e       phase_q, phase_d;
  logic              start_q, rd_en_q, pv_q, plot_q, busy_q, done_q, overflow_q;
  logic [X_W-1:0]    rd_x_q, px_q, x_q;
  logic [Y_W-1:0]    rd_y_q, py_q, y_q;
  logic [COL_W-1:0]  colour_q;
  logic [CNT_W-1:0]  count_q, box_idx_q, box_idx_d;
  logic [OFF_W-1:0]  off_q, off_d;

  logic              tbl_alloc, tbl_full, seg_last, tall;
  logic [X_W-1:0]    box_xmin, box_xmax, l_x, r_x, row_x, draw_x;
  logic [Y_W-1:0]    box_ymin, box_ymax, t_y, b_y, col_y, draw_y;
  logic [X_W:0]      r_e;
  logic [Y_W:0]      b_e;

  star_box_table #(
    .X_W       (X_W),
    .Y_W       (Y_W),
    .MAX_STARS (MAX_STARS),
    .MERGE_GAP (MERGE_GAP),
    .CNT_W     (CNT_W)
  ) u_table (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (state_q == ST_IDLE && start && !start_q),
    .pix_valid_i (pv_q),
    .pix_star_i  (rd_data != BG_COLOUR),
    .pix_x_i     (px_q),
    .pix_y_i     (py_q),
    .alloc_o     (tbl_alloc),
    .full_o      (tbl_full),
    .rd_idx_i    (box_idx_q),
    .rd_xmin_o   (box_xmin),
    .rd_xmax_o   (box_xmax),
    .rd_ymin_o   (box_ymin),
    .rd_ymax_o   (box_ymax)
  );

  // Padded, screen-clamped outline of the box currently being drawn.
  assign l_x = ({1'b0, box_xmin} >= PAD_X) ? X_W'({1'b0, box_xmin} - PAD_X) : '0;
  assign t_y = ({1'b0, box_ymin} >= PAD_Y) ? Y_W'({1'b0, box_ymin} - PAD_Y) : '0;
  assign r_e = {1'b0, box_xmax} + PAD_X;
  assign b_e = {1'b0, box_ymax} + PAD_Y;
  assign r_x = (r_e > MAX_X) ? MAX_X[X_W-1:0] : r_e[X_W-1:0];
  assign b_y = (b_e > MAX_Y) ? MAX_Y[Y_W-1:0] : b_e[Y_W-1:0];

  assign row_x = l_x + X_W'(off_q);
  assign col_y = t_y + Y_W'(off_q) + Y_W'(1);
  assign tall  = (b_y - t_y) > Y_W'(1);

  always_comb begin
    draw_x    = l_x;
    draw_y    = t_y;
    seg_last  = 1'b0;
    phase_d   = phase_q;
    off_d     = off_q + OFF_W'(1);
    box_idx_d = box_idx_q;
    case (phase_q)
      PH_TOP:   begin draw_x = row_x;                seg_last = (row_x == r_x); end
      PH_BOT:   begin draw_x = row_x; draw_y = b_y;  seg_last = (row_x == r_x); end
      PH_LEFT:  begin draw_y = col_y;                seg_last = (col_y == b_y - Y_W'(1)); end
      default:  begin draw_x = r_x;   draw_y = col_y; seg_last = (col_y == b_y - Y_W'(1)); end
    endcase
    if (seg_last) begin
      off_d = '0;
      case (phase_q)
        PH_TOP:  phase_d = PH_BOT;
        PH_BOT:  begin
          // Boxes only two rows tall have no column pixels left to plot.
          phase_d = tall ? PH_LEFT : PH_TOP;
          if (!tall) box_idx_d = box_idx_q + CNT_W'(1);
        end
        PH_LEFT: phase_d = PH_RIGHT;
        default: begin
          phase_d   = PH_TOP;
          box_idx_d = box_idx_q + CNT_W'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      // Armed high so a start held through reset must fall before it counts.
      start_q    <= 1'b1;
      rd_en_q    <= 1'b0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      pv_q       <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      plot_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      box_idx_q  <= '0;
      phase_q    <= PH_TOP;
      off_q      <= '0;
    end else begin
      start_q <= start;
      pv_q    <= rd_en_q;
      px_q    <= rd_x_q;
      py_q    <= rd_y_q;
      plot_q  <= 1'b0;
      done_q  <= 1'b0;
      if (tbl_alloc) count_q    <= count_q + CNT_W'(1);
      if (tbl_full)  overflow_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (start && !start_q) begin
            state_q    <= ST_SCAN;
            busy_q     <= 1'b1;
            rd_en_q    <= 1'b1;
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (rd_x_q == X_W'(SCREEN_W - 1)) begin
            rd_x_q <= '0;
            if (rd_y_q == Y_W'(SCREEN_H - 1)) begin
              rd_y_q  <= '0;
              rd_en_q <= 1'b0;
              state_q <= ST_FLUSH;
            end else begin
              rd_y_q <= rd_y_q + Y_W'(1);
            end
          end else begin
            rd_x_q <= rd_x_q + X_W'(1);
          end
        end
        ST_FLUSH: begin
          state_q   <= ST_DRAW;
          box_idx_q <= '0;
          phase_q   <= PH_TOP;
          off_q     <= '0;
        end
        ST_DRAW: begin
          // Boxes are allocated contiguously, so index == count ends the draw.
          if (box_idx_q == count_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            plot_q    <= 1'b1;
            x_q       <= draw_x;
            y_q       <= draw_y;
            colour_q  <= BOX_COLOUR;
            phase_q   <= phase_d;
            off_q     <= off_d;
            box_idx_q <= box_idx_d;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_x       = rd_x_q;
  assign rd_y       = rd_y_q;
  assign x          = x_q;
  assign y          = y_q;
  assign colour     = colour_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign star_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_multi_star_finder.sv
// Directed bench: two finders (MERGE_GAP 1 and 2) read the same frame model;
// outline plots are compared against outlines expanded from hand-derived boxes.
module tb_multi_star_finder;

  localparam int SW = 160;
  localparam int SH = 120;
  localparam int BUDGET = 25000;

  logic clk = 1'b0;
  logic reset, start;

  logic       rd_en_a, rd_en_b, plot_a, plot_b, busy_a, busy_b, done_a, done_b;
  logic       overflow_a, overflow_b;
  logic [7:0] rd_x_a, rd_x_b, x_a, x_b;
  logic [6:0] rd_y_a, rd_y_b, y_a, y_b;
  logic [2:0] rd_data_a, rd_data_b, colour_a, colour_b, star_count_a, star_count_b;

  logic [2:0]  frame [SH][SW];
  logic [14:0] got_a[$], got_b[$], exp_a[$], exp_b[$];

  int n_vec = 0;
  int n_err = 0;
  int rd_cnt, rd_first, rd_last, raster_err, colour_err, busy_first_err;
  int done_cyc_a, done_cyc_b;

  always #5 clk = ~clk;

  multi_star_finder dut_a (
    .clk(clk), .reset(reset), .start(start),
    .rd_en(rd_en_a), .rd_x(rd_x_a), .rd_y(rd_y_a), .rd_data(rd_data_a),
    .x(x_a), .y(y_a), .colour(colour_a), .plot(plot_a),
    .busy(busy_a), .done(done_a), .star_count(star_count_a), .overflow(overflow_a)
  );

  multi_star_finder #(.MERGE_GAP(2)) dut_b (
    .clk(clk), .reset(reset), .start(start),
    .rd_en(rd_en_b), .rd_x(rd_x_b), .rd_y(rd_y_b), .rd_data(rd_data_b),
    .x(x_b), .y(y_b), .colour(colour_b), .plot(plot_b),
    .busy(busy_b), .done(done_b), .star_count(star_count_b), .overflow(overflow_b)
  );

  // Frame memory: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    rd_data_a <= rd_en_a ? frame[rd_y_a][rd_x_a] : 3'b111;
    rd_data_b <= rd_en_b ? frame[rd_y_b][rd_x_b] : 3'b111;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] pk(input int px, input int py);
    return {px[7:0], py[6:0]};
  endfunction

  // Expected outline order: top row, bottom row, left column, right column.
  task automatic add_box(input bit to_b, input int l, input int r, input int t, input int b);
    logic [14:0] v[$];
    for (int i = l; i <= r; i++) v.push_back(pk(i, t));
    for (int i = l; i <= r; i++) v.push_back(pk(i, b));
    for (int j = t + 1; j <= b - 1; j++) v.push_back(pk(l, j));
    for (int j = t + 1; j <= b - 1; j++) v.push_back(pk(r, j));
    foreach (v[k]) begin
      if (to_b) exp_b.push_back(v[k]);
      else      exp_a.push_back(v[k]);
    end
  endtask

  task automatic clear_frame();
    for (int j = 0; j < SH; j++)
      for (int i = 0; i < SW; i++)
        frame[j][i] = 3'b000;
  endtask

  // Starts a run (called at a negedge) and records everything up to done.
  task automatic run_frame();
    bit a_done = 1'b0;
    bit b_done = 1'b0;
    got_a.delete();
    got_b.delete();
    rd_cnt = 0; rd_first = -1; rd_last = -1; raster_err = 0;
    colour_err = 0; busy_first_err = 0; done_cyc_a = -1; done_cyc_b = -1;
    start = 1'b1;
    for (int cyc = 0; cyc < BUDGET && !(a_done && b_done); cyc++) begin
      @(negedge clk);
      if (cyc == 2)    start = 1'b0;
      if (cyc == 1000) start = 1'b1;
      if (cyc == 1002) start = 1'b0;
      if (cyc == 0 && !(busy_a && busy_b)) busy_first_err++;
      if (rd_en_a) begin
        rd_cnt++;
        if (rd_first < 0) rd_first = cyc;
        rd_last = cyc;
        if (rd_x_a != 8'(cyc % SW) || rd_y_a != 7'(cyc / SW)) raster_err++;
      end
      if (plot_a) begin
        got_a.push_back({x_a, y_a});
        if (colour_a != 3'b010) colour_err++;
      end
      if (plot_b) begin
        got_b.push_back({x_b, y_b});
        if (colour_b != 3'b010) colour_err++;
      end
      if (done_a && !a_done) begin a_done = 1'b1; done_cyc_a = cyc; end
      if (done_b && !b_done) begin b_done = 1'b1; done_cyc_b = cyc; end
    end
    @(negedge clk);
    check("busy_at_start", busy_first_err, 0);
    check("busy_after_done", {busy_a, busy_b, done_a, done_b}, 4'b0000);
  endtask

  task automatic compare_plots();
    check("plot_count_a", got_a.size(), exp_a.size());
    check("plot_count_b", got_b.size(), exp_b.size());
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++)
      check($sformatf("plot_a[%0d]", i), got_a[i], exp_a[i]);
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
      check($sformatf("plot_b[%0d]", i), got_b[i], exp_b[i]);
    check("plot_colour", colour_err, 0);
  endtask

  initial begin
    int busy_seen;
    int plots;
    reset = 1'b1;
    start = 1'b0;
    clear_frame();
    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy_a, done_a, plot_a, rd_en_a, overflow_a}, 5'b0);
    check("rst_count", star_count_a, 0);
    check("rst_xy", {x_a, y_a, rd_x_a, rd_y_a, colour_a}, 33'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Blank frame: full scan, no plots, done 19202 cycles after the start edge.
    run_frame();
    check("blank_rd_count", rd_cnt, 19200);
    check("blank_rd_first", rd_first, 0);
    check("blank_rd_last", rd_last, 19199);
    check("blank_raster", raster_err, 0);
    check("blank_done_a", done_cyc_a, 19202);
    check("blank_done_b", done_cyc_b, 19202);
    check("blank_plots", got_a.size() + got_b.size(), 0);
    check("blank_count", {star_count_a, star_count_b}, 6'd0);
    check("blank_ovf", {overflow_a, overflow_b}, 2'b00);

    // Five separate clusters for gap 1; gap 2 joins (30,30) with (30,32).
    frame[0][0]     = 3'b111;
    frame[20][10]   = 3'b001;
    frame[20][11]   = 3'b100;
    frame[21][10]   = 3'b011;
    frame[30][30]   = 3'b010;
    frame[32][30]   = 3'b101;
    frame[119][159] = 3'b110;

    // Reset mid-SCAN with start held high throughout.
    start = 1'b1;
    repeat (200) @(negedge clk);
    check("mid_scan_busy", busy_a, 1'b1);
    check("mid_scan_count", star_count_a, 1);
    reset = 1'b1;
    @(negedge clk);
    check("scan_rst_ctrl", {busy_a, plot_a, rd_en_a, done_a}, 4'b0);
    check("scan_rst_count", {star_count_a, star_count_b}, 6'd0);
    @(negedge clk);
    reset = 1'b0;
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_a || busy_b) busy_seen++;
    end
    check("held_start_no_run", busy_seen, 0);
    start = 1'b0;
    repeat (2) @(negedge clk);

    exp_a.delete();
    exp_b.delete();
    add_box(1'b0, 0, 1, 0, 1);
    add_box(1'b0, 9, 12, 19, 22);
    add_box(1'b0, 29, 31, 29, 31);
    add_box(1'b0, 29, 31, 31, 33);
    add_box(1'b1, 0, 1, 0, 1);
    add_box(1'b1, 9, 12, 19, 22);
    add_box(1'b1, 29, 31, 29, 33);
    add_box(1'b1, 158, 159, 118, 119);
    run_frame();
    check("stars_raster", raster_err, 0);
    check("stars_count_a", star_count_a, 4);
    check("stars_ovf_a", overflow_a, 1'b1);
    check("stars_count_b", star_count_b, 4);
    check("stars_ovf_b", overflow_b, 1'b0);
    check("stars_done_a", done_cyc_a, 19234);
    check("stars_done_b", done_cyc_b, 19234);
    compare_plots();
    repeat (3) @(negedge clk);
    check("hold_count", {star_count_a, star_count_b}, {3'd4, 3'd4});
    check("hold_ovf", {overflow_a, overflow_b}, 2'b10);

    // Reset mid-DRAW after a few outline pixels.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    plots = 0;
    for (int c = 0; c < BUDGET && plots < 5; c++) begin
      @(negedge clk);
      if (plot_a) plots++;
    end
    check("draw_reached", plots, 5);
    reset = 1'b1;
    @(negedge clk);
    check("draw_rst_ctrl", {busy_a, plot_a, done_a, overflow_a}, 4'b0);
    check("draw_rst_count", star_count_a, 0);
    reset = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
